// File: rtl/pll_rst_pkg.sv
// rtl/pll_rst_pkg.sv - state encoding and default constants for the PLL reset sequencer
package pll_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABILIZE = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES        = 2;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 256;
  localparam int unsigned DEF_STAGGER_CYCLES     = 16;
  localparam int unsigned DEF_CNT_W              = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_bit_synchronizer.sv
// rtl/pll_reset_sequencer_bit_synchronizer.sv - async-reset flop chain bringing a single bit into clk
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the chain; the last stage is the safe copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - staged periph/core reset release from PLL lock; optional loss counter via PLL_RST_LOCK_LOSS_COUNT_EN
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned STAGGER_CYCLES     = DEF_STAGGER_CYCLES,
  parameter int unsigned CNT_W              = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             soft_reset_req,
  input  logic             clear_sticky,
  output logic             periph_reset_n,
  output logic             core_reset_n,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] lock_loss_count
);

  // One counter serves both the stability window and the stagger window
  localparam int unsigned CNT_MAX = max_u(LOCK_STABLE_CYCLES, STAGGER_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          periph_q;
  logic          core_q;
  logic          ready_q;
  logic          lost_q;
  logic          lk;
  logic          in_release_or_run;
  logic          loss_evt;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (lk)
  );

  // Lock loss only counts once the peripheral reset has been released
  assign in_release_or_run = (state_q == RELEASE) || (state_q == RUN);
  assign loss_evt          = in_release_or_run && !lk;

  // Sequencer FSM with registered reset outputs and sticky loss flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      ready_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      // Clear first so that a loss on the same edge overrides it below
      if (clear_sticky) begin
        lost_q <= 1'b0;
      end
      case (state_q)
        WAIT_LOCK: begin
          if (lk) begin
            state_q <= STABILIZE;
            cnt_q   <= '0;
          end
        end
        STABILIZE: begin
          if (!lk || soft_reset_req) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q  <= RELEASE;
            periph_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RELEASE, RUN: begin
          if (loss_evt) begin
            state_q  <= LOST;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            ready_q  <= 1'b0;
            lost_q   <= 1'b1;
            cnt_q    <= '0;
          end else if (soft_reset_req) begin
            state_q  <= WAIT_LOCK;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
          end else if (state_q == RELEASE) begin
            if (cnt_q == STAGGER_LAST) begin
              state_q <= RUN;
              core_q  <= 1'b1;
              ready_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        LOST: begin
          state_q <= WAIT_LOCK;
          cnt_q   <= '0;
        end
        default: begin
          state_q  <= WAIT_LOCK;
          cnt_q    <= '0;
          periph_q <= 1'b0;
          core_q   <= 1'b0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign periph_reset_n = periph_q;
  assign core_reset_n   = core_q;
  assign ready          = ready_q;
  assign lock_lost      = lost_q;

`ifdef PLL_RST_LOCK_LOSS_COUNT_EN
  logic [CNT_W-1:0] loss_cnt_q;

  // Saturating count of lock-loss events; survives clear_sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
    end else if (loss_evt && (loss_cnt_q != {CNT_W{1'b1}})) begin
      loss_cnt_q <= loss_cnt_q + CNT_W'(1);
    end
  end

  assign lock_loss_count = loss_cnt_q;
`else
  assign lock_loss_count = '0;
`endif

endmodule
